// File: rtl/mont_pkg.sv
// Shared constants, FSM encoding and word-index helper for the Montgomery
// iteration controller.
package mont_pkg;

  localparam int N  = 6;
  localparam int W  = 3;
  localparam int NW = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int word_lsb(input int j);
    return j * W;
  endfunction

endpackage

// File: rtl/mont_final_sub.sv
// Final conditional subtraction of Montgomery multiplication: returns S-M when
// S >= M, otherwise S, all at N+1 bits.
module mont_final_sub
  import mont_pkg::*;
(
  input  logic [N:0]   i_s,
  input  logic [N-1:0] i_m,
  output logic [N:0]   o_r
);

  logic [N:0] w_m_ext;

  assign w_m_ext = {1'b0, i_m};
  assign o_r     = (i_s >= w_m_ext) ? (i_s - w_m_ext) : i_s;

endmodule

// File: rtl/mont_iter_ctrl.sv
// Bit-serial Montgomery iteration controller: scans X LSB first, issues one
// kernel iteration per bit, feeds S back, then applies the final subtraction.
module mont_iter_ctrl
  import mont_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    x,
  input  logic [N-1:0]    y,
  input  logic [N-1:0]    m,
  output logic            busy,
  output logic            result_valid,
  output logic [N-1:0]    result,
  output logic            err,
  output logic            k_start,
  output logic            k_xi,
  output logic [N-1:0]    k_y,
  output logic [N-1:0]    k_m,
  output logic [NW*W-1:0] k_s,
  input  logic            k_done,
  input  logic [NW*W-1:0] k_s_new
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        r_state;
  logic [N-1:0]  r_x;
  logic [N-1:0]  r_y;
  logic [N-1:0]  r_m;
  logic [W-1:0]  r_s [NW];
  logic [IW-1:0] r_i;
  logic [CW-1:0] r_cnt;

  logic [NW*W-1:0] w_s_flat;
  logic [N:0]      w_fin;

  for (genvar j = 0; j < NW; j++) begin : g_sword
    assign w_s_flat[word_lsb(j) +: W] = r_s[j];
  end

  // S < 2M by construction, so N+1 bits of the partial sum are enough.
  mont_final_sub u_final_sub (
    .i_s (w_s_flat[N:0]),
    .i_m (r_m),
    .o_r (w_fin)
  );

  assign k_s  = w_s_flat;
  assign k_y  = r_y;
  assign k_m  = r_m;
  assign k_xi = r_x[r_i];

  // Control outputs are registered from the current state, so each one
  // appears one cycle after the state it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_m          <= '0;
      r_i          <= '0;
      r_cnt        <= '0;
      for (int j = 0; j < NW; j++) r_s[j] <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      err          <= 1'b0;
      k_start      <= 1'b0;
    end else begin
      k_start      <= (r_state == ISSUE);
      busy         <= (r_state inside {LOAD, ISSUE, WAIT, FINAL});
      result_valid <= (r_state == DONE);

      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_m     <= m;
            r_i     <= '0;
            for (int j = 0; j < NW; j++) r_s[j] <= '0;
            err     <= 1'b0;
            r_state <= LOAD;
          end
        end
        LOAD: r_state <= ISSUE;
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // A k_done arriving on the expiry cycle still counts as success.
          if (k_done) begin
            for (int j = 0; j < NW; j++) r_s[j] <= k_s_new[word_lsb(j) +: W];
            if (r_i == IW'(N - 1)) begin
              r_state <= FINAL;
            end else begin
              r_i     <= r_i + 1'b1;
              r_state <= ISSUE;
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            err     <= 1'b1;
            result  <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FINAL: begin
          result  <= w_fin[N-1:0];
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_iter_ctrl.sv
// Self-checking bench for mont_iter_ctrl with a behavioural per-iteration
// kernel of programmable response time and a modular-arithmetic reference.
module tb_mont_iter_ctrl;
  import mont_pkg::*;

  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [N-1:0]    x = '0, y = '0, m = '0;
  logic            busy, result_valid, err, k_start, k_xi;
  logic [N-1:0]    result, k_y, k_m;
  logic [NW*W-1:0] k_s;
  logic            k_done = 1'b0;
  logic [NW*W-1:0] k_s_new = '0;

  int n_chk  = 0;
  int n_fail = 0;

  // Kernel behaviour: k_done is seen by the controller on the L-th rising
  // edge after k_start rises; hang suppresses the response entirely.
  int  lat_l = 2;
  bit  hang  = 1'b0;
  bit  kpend = 1'b0;
  int  kcnt  = 0;

  mont_iter_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .m(m),
    .busy(busy), .result_valid(result_valid), .result(result), .err(err),
    .k_start(k_start), .k_xi(k_xi), .k_y(k_y), .k_m(k_m), .k_s(k_s),
    .k_done(k_done), .k_s_new(k_s_new)
  );

  always #5 clk = ~clk;

  function automatic int kstep(input int s, input int xi, input int yy, input int mm);
    int t;
    t = s + xi * yy;
    return (t + (t % 2) * mm) / 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k_done <= 1'b0;
      kpend  <= 1'b0;
      kcnt   <= 0;
    end else if (k_start && !hang) begin
      k_s_new <= (NW*W)'(kstep(int'(k_s), int'(k_xi), int'(k_y), int'(k_m)));
      if (lat_l <= 2) begin
        k_done <= 1'b1;
        kpend  <= 1'b0;
      end else begin
        k_done <= 1'b0;
        kpend  <= 1'b1;
        kcnt   <= lat_l - 3;
      end
    end else begin
      k_done <= 1'b0;
      if (kpend) begin
        if (kcnt == 0) begin
          k_done <= 1'b1;
          kpend  <= 1'b0;
        end else begin
          kcnt <= kcnt - 1;
        end
      end
    end
  end

  // X*Y*2^-N mod M found by searching for r with r*2^N == X*Y (mod M).
  function automatic int ref_mont(input int xx, input int yy, input int mm);
    int p;
    p = (xx * yy) % mm;
    for (int r = 0; r < mm; r++)
      if (((r << N) % mm) == p) return r;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Launch one operation; lat counts edges from the start-sampling edge to
  // the edge where result_valid rises.
  task automatic run_op(input int xx, input int yy, input int mm,
                        output int res, output int e, output int lat, output bit seen);
    @(negedge clk);
    x = N'(xx); y = N'(yy); m = N'(mm);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!result_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    seen = result_valid;
    res  = int'(result);
    e    = int'(err);
  endtask

  typedef struct {
    int x, y, m, l;
    int exp_res;
    int exp_err;
    int exp_lat;
  } vec_t;

  vec_t tv [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int res, e, lat, cnt, kcount, mm, xx, yy, exp_r;
    bit seen;

    tv[0] = '{x: 5,  y: 7,  m: 13, l: 2, exp_res: 4,  exp_err: 0, exp_lat: 21};
    tv[1] = '{x: 1,  y: 1,  m: 13, l: 2, exp_res: 12, exp_err: 0, exp_lat: 21};
    tv[2] = '{x: 62, y: 62, m: 63, l: 3, exp_res: 1,  exp_err: 0, exp_lat: 27};
    tv[3] = '{x: 0,  y: 9,  m: 13, l: 4, exp_res: 0,  exp_err: 0, exp_lat: 33};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_kstart", 32'(k_start), 0);
    chk("rst_ks", 32'(k_s), 0);
    chk("rst_km", 32'(k_m), 0);

    foreach (tv[i]) begin
      lat_l = tv[i].l;
      run_op(tv[i].x, tv[i].y, tv[i].m, res, e, lat, seen);
      chk($sformatf("vec%0d_seen", i), 32'(seen), 1);
      chk($sformatf("vec%0d_result", i), 32'(res), 32'(tv[i].exp_res));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tv[i].exp_lat));
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), 32'(result_valid), 0);
      chk($sformatf("vec%0d_hold", i), 32'(result), 32'(tv[i].exp_res));
    end

    // Kernel never answers: timeout path.
    hang = 1'b1;
    lat_l = 2;
    run_op(5, 7, 13, res, e, lat, seen);
    chk("tmo_seen", 32'(seen), 1);
    chk("tmo_err", 32'(e), 1);
    chk("tmo_result", 32'(res), 0);
    chk("tmo_latency", 32'(lat), 32'(TMO + 3));
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", 32'(err), 1);
    hang = 1'b0;
    run_op(5, 7, 13, res, e, lat, seen);
    chk("tmo_clear_err", 32'(e), 0);
    chk("tmo_clear_result", 32'(res), 4);

    // start held high across an operation.
    @(negedge clk);
    x = 6'd3; y = 6'd4; m = 6'd11;
    start = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (result_valid) begin
        cnt++;
        start = 1'b0;
        chk("held_result", 32'(result), 32'(ref_mont(3, 4, 11)));
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(cnt), 1);
    chk("held_idle", 32'(busy), 0);

    // Reset during the third iteration.
    @(negedge clk);
    x = 6'd5; y = 6'd7; m = 6'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kcount = 0;
    for (int c = 0; c < 200 && kcount < 3; c++) begin
      @(negedge clk);
      if (k_start) kcount++;
    end
    chk("rstmid_reached", 32'(kcount), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_kstart", 32'(k_start), 0);
    chk("rstmid_valid", 32'(result_valid), 0);
    chk("rstmid_ks", 32'(k_s), 0);
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (result_valid || busy) cnt++;
    end
    chk("rstmid_quiet", 32'(cnt), 0);
    run_op(5, 7, 13, res, e, lat, seen);
    chk("rstmid_fresh_seen", 32'(seen), 1);
    chk("rstmid_fresh_result", 32'(res), 4);

    // Random sweep of odd moduli.
    for (int k = 0; k < 40; k++) begin
      mm = 2 * int'($urandom_range(1, 31)) + 1;
      xx = int'($urandom_range(0, mm - 1));
      yy = int'($urandom_range(0, mm - 1));
      lat_l = int'($urandom_range(2, 4));
      exp_r = ref_mont(xx, yy, mm);
      run_op(xx, yy, mm, res, e, lat, seen);
      chk($sformatf("rnd%0d_seen", k), 32'(seen), 1);
      chk($sformatf("rnd%0d_m%0d_x%0d_y%0d", k, mm, xx, yy), 32'(res), 32'(exp_r));
      chk($sformatf("rnd%0d_lt_m", k), 32'(res < mm), 1);
      chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'(N * (lat_l + 1) + 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_iter_ctrl.md
Name: mont_iter_ctrl

Overview:
- Iteration controller that sits directly upstream of the word-serial Montgomery kernel and consumes its output.
- Accepts a full operand set (X, Y, M) and scans X bit-serially, LSB first, issuing one kernel iteration per bit.
- After each iteration it captures the kernel's partial sum S and feeds it back for the next bit.
- After N iterations it performs the final conditional subtraction and returns X*Y*2^-N mod M.

Parameters:
- N, 6: operand width in bits.
- W, 3: kernel word width.
- NW, 3: number of words in S, equal to (N+W)/W.
- TIMEOUT, 64: maximum cycles to wait for k_done before flagging an error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- x  in  N  multiplier X; must be < M.
- y  in  N  multiplicand Y; must be < M.
- m  in  N  modulus M; must be odd.
- busy  out  1  high from LOAD through FINAL.
- result_valid  out  1  one-cycle pulse in DONE.
- result  out  N  Montgomery product; held until the next start.
- err  out  1  sticky kernel-timeout flag; cleared by the next accepted start.
- k_start  out  1  one-cycle iteration pulse to the kernel.
- k_xi  out  1  current bit of X.
- k_y  out  N  registered Y.
- k_m  out  N  registered M.
- k_s  out  NW*W  current partial sum; word j occupies bits [j*W +: W].
- k_done  in  1  kernel iteration complete; level or pulse.
- k_s_new  in  NW*W  kernel result, valid while k_done is high.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal S 0, bit index 0, timeout counter 0.
- Reset mid-operation aborts immediately. k_start drops on the reset cycle and no result_valid is produced.
- IDLE: if start is high, latch x, y and m, clear S and the bit index, clear err, go to LOAD. If start is low, stay.
- LOAD: one cycle, then go to ISSUE. busy is high from LOAD onward.
- ISSUE: drive k_start=1 for exactly one cycle with k_xi=X[i]. Clear the timeout counter and go to WAIT.
- WAIT:
  - k_done=1: S <= k_s_new. If i==N-1 go to FINAL, else i <= i+1 and go to ISSUE.
  - Timeout counter reaches TIMEOUT-1 without k_done: set err, go to DONE; result is forced to 0.
- FINAL:
  - Take S from its NW*W bits, truncated to N+1 bits since S < 2M is guaranteed.
  - If S >= M then result <= S-M, else result <= S, computed at N+1-bit width.
  - Go to DONE.
- DONE: result_valid=1 for one cycle, busy=0, then go to IDLE.
- k_s, k_xi, k_y and k_m stay stable from ISSUE through the WAIT exit.
- start asserted while not in IDLE is ignored and not queued.
- k_done high in ISSUE, before k_start has been issued, is ignored.
- k_done pulse that coincides with timeout expiry: k_done wins.
- Latency: with kernel response L cycles (k_start edge to k_done edge), result_valid rises N*(L+1)+3 cycles after the start-sampling edge.
- Arithmetic per iteration, implemented by the kernel: S <- (S + xi*Y + q*M)/2 with q = LSB of (S + xi*Y).

Decomposition:
- Shared package mont_pkg holds:
  - constants N, W, NW;
  - state encoding IDLE=0, LOAD=1, ISSUE=2, WAIT=3, FINAL=4, DONE=5;
  - word-index helper (j*W).
- Natural sub-module: mont_final_sub, a combinational (N+1)-bit compare-and-subtract used in FINAL.
- Benches use a behavioural kernel model of the per-iteration arithmetic, with programmable L.

Test Plan:
- M=13, X=5, Y=7, L=2: result_valid after 6*3+3=21 cycles, result=4, err=0.
- M=13, X=1, Y=1: result=12, since 2^-6 mod 13 = 12.
- M=63, X=62, Y=62: result=1, which exercises the final-subtract path (S>=M at least once across a random sweep). X=0, Y=9: result=0.
- Kernel model never asserts k_done: err=1 after TIMEOUT cycles in WAIT, result_valid pulses, result=0. The next start clears err.
- start held high during an operation: exactly one result_valid, no second operation. rst at iteration 3: outputs reset next cycle, no result_valid, and a fresh start then completes correctly.
- Random sweep of odd M < 64 with X, Y < M against a reference model: result always equals X*Y*2^-6 mod M and is < M.
